// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder: one 4-bit carry-lookahead slice per clock, LSB nibble first.
// Optional subtract mode is enabled by defining CLA_NIBBLE_SUB_EN (adds the 'sub' input).
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
`ifdef CLA_NIBBLE_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_r, b_r, partial, partial_next;
    logic             carry_r;
    logic [IDX_W-1:0] idx;
    logic [3:0]       a_nib, b_nib, p, g, sum_nib;
    logic [4:0]       c;
    logic             last;

    // Full 4-bit lookahead: every carry is a flat sum of products of P/G and the incoming carry.
    function automatic logic [4:0] lookahead(input logic [3:0] pp, input logic [3:0] gg,
                                             input logic c0);
        logic [4:0] cl;
        cl[0] = c0;
        cl[1] = gg[0] | (pp[0] & c0);
        cl[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
        cl[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & c0);
        cl[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
              | (pp[3] & pp[2] & pp[1] & pp[0] & c0);
        return cl;
    endfunction

    always_comb begin
        a_nib        = a_r[4*int'(idx) +: 4];
        b_nib        = b_r[4*int'(idx) +: 4];
        p            = a_nib ^ b_nib;
        g            = a_nib & b_nib;
        c            = lookahead(p, g, carry_r);
        sum_nib      = p ^ c[3:0];
        partial_next = partial;
        partial_next[4*int'(idx) +: 4] = sum_nib;
        last         = (idx == IDX_W'(NIB - 1));
    end

    always_comb begin
        state_next = state;
        busy       = (state == RUN);
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            S       <= '0;
            Co      <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            partial <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= A;
                        idx     <= '0;
                        partial <= '0;
`ifdef CLA_NIBBLE_SUB_EN
                        // Two's complement subtract: invert B and force the initial carry.
                        b_r     <= sub ? ~B : B;
                        carry_r <= sub ? 1'b1 : Ci;
`else
                        b_r     <= B;
                        carry_r <= Ci;
`endif
                    end
                end
                RUN: begin
                    partial <= partial_next;
                    carry_r <= c[4];
                    if (last) begin
                        S    <= partial_next;
                        Co   <= c[4];
                        done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Self-checking bench for cla_nibble_serial_adder: directed vector table, multi-cycle
// corner sequences and random operands checked against plain integer addition.
module tb_cla_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A, B;
    logic         Ci;
    logic         busy, done, Co;
    logic [W-1:0] S;
`ifdef CLA_NIBBLE_SUB_EN
    logic         sub;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cla_nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
`ifdef CLA_NIBBLE_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Co    (Co)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci);
        return {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    endfunction

    // Waits (bounded) for the done pulse; lat is edges after the accepting edge, -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic [W-1:0] exp_s, input logic exp_co);
        int lat;
        @(negedge clk);
        A = a; B = b; Ci = ci; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Ci = ~ci;
        check({name, " busy_after_start"}, 32'(busy), 32'd1);
        wait_done(lat);
        check({name, " latency"}, 32'(lat), 32'(NIB));
        check({name, " S"}, 32'(S), 32'(exp_s));
        check({name, " Co"}, 32'(Co), 32'(exp_co));
        check({name, " busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({name, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W:0] r;
        logic [W-1:0] ra, rb;
        logic rci;
        int lat;
        logic seen_done;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};

        rst = 1'b1; start = 1'b0; A = '0; B = '0; Ci = 1'b0;
`ifdef CLA_NIBBLE_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("idle busy", 32'(busy), 32'd0);
            check("idle done", 32'(done), 32'd0);
            check("idle S", 32'(S), 32'd0);
            check("idle Co", 32'(Co), 32'd0);
        end

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co);

        // Start held high with changing operands; second request lands in the done cycle.
        @(negedge clk);
        A = 16'h1111; B = 16'h2222; Ci = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        A = 16'hDEAD; B = 16'hBEEF; Ci = 1'b1;
        wait_done(lat);
        check("b2b first latency", 32'(lat), 32'(NIB));
        check("b2b first S", 32'(S), 32'h3333);
        check("b2b first Co", 32'(Co), 32'd0);
        A = 16'hF00F; B = 16'h1FF1; Ci = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b second busy", 32'(busy), 32'd1);
        wait_done(lat);
        check("b2b second latency", 32'(lat), 32'(NIB));
        check("b2b second S", 32'(S), 32'h1000);
        check("b2b second Co", 32'(Co), 32'd1);

        // Reset during the second RUN cycle discards the operation.
        @(negedge clk);
        A = 16'h1234; B = 16'h1111; Ci = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst S", 32'(S), 32'd0);
        check("rst Co", 32'(Co), 32'd0);
        check("rst done", 32'(done), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            seen_done = seen_done | done;
        end
        check("rst no done pulse", 32'(seen_done), 32'd0);
        run_op("after rst", 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom); rb = W'($urandom); rci = 1'($urandom);
            r = ref_add(ra, rb, rci);
            run_op($sformatf("rand%0d", i), ra, rb, rci, r[W-1:0], r[W]);
        end

`ifdef CLA_NIBBLE_SUB_EN
        sub = 1'b1;
        run_op("sub 5-7", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
        run_op("sub 7-5", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
        for (int i = 0; i < 10; i++) begin
            ra = W'($urandom); rb = W'($urandom); rci = 1'($urandom);
            r = ref_add(ra, ~rb, 1'b1);
            run_op($sformatf("rsub%0d", i), ra, rb, rci, r[W-1:0], r[W]);
        end
        sub = 1'b0;
        run_op("sub off", 16'h0007, 16'h0005, 1'b1, 16'h000D, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
